// File: rtl/spike_rx_counter_pkg.sv
// Shared definitions for the spike receive counter and its synchronizer.
package spike_rx_counter_pkg;

    // A metastability filter needs at least two flops to be useful.
    localparam int SYNC_STAGES_MIN = 2;

    // Window counter state: waiting for a window start, or counting one.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

endpackage

// File: rtl/spike_sync_edge.sv
// Synchronizes an asynchronous spike line into clk and emits a one-cycle
// registered strobe for every rising edge it sees. Falling edges are ignored.
// Pulses narrower than one clk period may be missed.
module spike_sync_edge
    import spike_rx_counter_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic spike_in,
    output logic spike_pulse
);

    // Anything shorter than the minimum chain is silently lengthened.
    localparam int STAGES = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

    logic [STAGES-1:0] sync_q;
    logic              s_sync;
    logic              s_prev;

    assign s_sync = sync_q[STAGES-1];

    // Synchronizer chain, one-cycle history and registered rising-edge strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: the synchronizer flops are reset too, so a line held high through
        // reset shows up as one fresh rising edge after release, never as X.
        if (!reset_n) begin
            sync_q      <= '0;
            s_prev      <= 1'b0;
            spike_pulse <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every stage sample the previous
            // stage's old value, which is what makes this a shift chain.
            sync_q      <= {sync_q[STAGES-2:0], spike_in};
            s_prev      <= s_sync;
            spike_pulse <= s_sync & ~s_prev;
        end
    end

endmodule

// File: rtl/spike_rx_counter.sv
// Receive end of the spike oscillator link: counts synchronized spike edges
// over programmable windows of clk cycles and hands each window count to the
// downstream rate logic over a valid/ready handshake.
module spike_rx_counter
    import spike_rx_counter_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int WIN_W       = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             spike_in,
    input  logic             enable,
    input  logic [WIN_W-1:0] win_len,
    output logic             spike_pulse,
    output logic [CNT_W-1:0] count_data,
    output logic             count_valid,
    input  logic             count_ready,
    output logic             count_sat,
    output logic             drop
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state;
    logic [WIN_W-1:0]   win_left;
    logic [CNT_W-1:0]   acc;
    logic               acc_sat;

    logic [CNT_W-1:0]   acc_next;
    logic               sat_next;
    logic               win_term;
    logic               start_ok;
    logic               out_free;

    spike_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk         (clk),
        .reset_n     (reset_n),
        .spike_in    (spike_in),
        .spike_pulse (spike_pulse)
    );

    // A new window may begin only with counting enabled and a non-zero length.
    assign start_ok = enable && (win_len != '0);

    // The last cycle of a window is the one with a single cycle left.
    assign win_term = (state == ST_COUNT) && (win_left == WIN_W'(1));

    // The output register can take a result if it is empty or being emptied now.
    assign out_free = !count_valid || count_ready;

    // Saturating accumulator update for the current cycle's spike strobe.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        acc_next = acc;
        sat_next = acc_sat;
        if (spike_pulse) begin
            if (acc == CNT_MAX) begin
                // The count is pinned; the sat bit records that spikes were lost.
                sat_next = 1'b1;
            end else begin
                acc_next = acc + CNT_W'(1);
            end
        end
    end

    // Window state machine: window length down-counter and spike accumulator.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            win_left <= '0;
            acc      <= '0;
            acc_sat  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    acc     <= '0;
                    acc_sat <= 1'b0;
                    if (start_ok) begin
                        win_left <= win_len;
                        state    <= ST_COUNT;
                    end
                end

                ST_COUNT: begin
                    if (win_term) begin
                        // The window is complete even if enable just fell; its
                        // result goes to the output stage either way. Reload
                        // here so back-to-back windows have no dead cycle.
                        acc     <= '0;
                        acc_sat <= 1'b0;
                        if (start_ok) begin
                            win_left <= win_len;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (!enable) begin
                        // Abort: the partial count is thrown away.
                        acc     <= '0;
                        acc_sat <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        win_left <= win_left - WIN_W'(1);
                        acc      <= acc_next;
                        acc_sat  <= sat_next;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output register: capture the finished window, release on accept, flag drops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_data  <= '0;
            count_valid <= 1'b0;
            count_sat   <= 1'b0;
            drop        <= 1'b0;
        end else begin
            if (win_term && out_free) begin
                // The terminal cycle's own spike is part of the ending window,
                // so the captured value is the updated accumulator.
                count_data  <= acc_next;
                count_sat   <= sat_next;
                count_valid <= 1'b1;
            end else if (count_ready) begin
                count_valid <= 1'b0;
            end

            if (win_term && !out_free) begin
                drop <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spike_rx_counter.sv
// Self-checking bench for spike_rx_counter. Two instances share all inputs:
// one with the default 16-bit count and one with a 4-bit count so that
// saturation is reachable. A window-level reference model predicts every
// output of both instances on every cycle.
module tb_spike_rx_counter;
    import spike_rx_counter_pkg::*;

    localparam int SS    = 2;
    localparam int WIN_W = 24;

    logic             clk         = 1'b0;
    logic             reset_n     = 1'b0;
    logic             spike_in    = 1'b0;
    logic             enable      = 1'b0;
    logic [WIN_W-1:0] win_len     = '0;
    logic             count_ready = 1'b0;

    logic        spike_pulse,   spike_pulse_4;
    logic [15:0] count_data;
    logic [3:0]  count_data_4;
    logic        count_valid,   count_valid_4;
    logic        count_sat,     count_sat_4;
    logic        drop,          drop_4;

    spike_rx_counter #(.CNT_W(16), .WIN_W(WIN_W), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset_n(reset_n), .spike_in(spike_in), .enable(enable),
        .win_len(win_len), .spike_pulse(spike_pulse), .count_data(count_data),
        .count_valid(count_valid), .count_ready(count_ready),
        .count_sat(count_sat), .drop(drop)
    );

    spike_rx_counter #(.CNT_W(4), .WIN_W(WIN_W), .SYNC_STAGES(SS)) dut_4 (
        .clk(clk), .reset_n(reset_n), .spike_in(spike_in), .enable(enable),
        .win_len(win_len), .spike_pulse(spike_pulse_4), .count_data(count_data_4),
        .count_valid(count_valid_4), .count_ready(count_ready),
        .count_sat(count_sat_4), .drop(drop_4)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: spike samples, window end times and true (unbounded) counts.
    logic [7:0] hist;
    bit  m_pulse;
    bit  m_active;
    int  m_end;
    int  m_n;
    bit  m_valid;
    int  m_res;
    bit  m_drop;
    int  cyc = 0;

    // Accepted results, recorded as the consumer sees them.
    int q16[$];
    int q4[$];
    int qs4[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int n, input int maxv);
        return (n > maxv) ? maxv : n;
    endfunction

    task automatic model_reset();
        hist     = '0;
        m_pulse  = 1'b0;
        m_active = 1'b0;
        m_end    = 0;
        m_n      = 0;
        m_valid  = 1'b0;
        m_res    = 0;
        m_drop   = 1'b0;
    endtask

    // One clock edge of the model, using the inputs present before the edge.
    task automatic model_edge();
        bit start_ok;
        bit done;
        int res;
        start_ok = enable && (win_len != 0);
        done     = 1'b0;
        res      = 0;
        cyc++;
        if (m_active) begin
            m_n += int'(m_pulse);
            if (cyc == m_end) begin
                done = 1'b1;
                res  = m_n;
                if (start_ok) begin
                    m_end = cyc + int'(win_len);
                    m_n   = 0;
                end else begin
                    m_active = 1'b0;
                end
            end else if (!enable) begin
                m_active = 1'b0;
            end
        end else if (start_ok) begin
            m_active = 1'b1;
            m_end    = cyc + int'(win_len);
            m_n      = 0;
        end

        if (done) begin
            if (!m_valid || count_ready) begin
                m_valid = 1'b1;
                m_res   = res;
            end else begin
                m_drop = 1'b1;
            end
        end else if (m_valid && count_ready) begin
            m_valid = 1'b0;
        end

        hist    = {hist[6:0], spike_in};
        m_pulse = hist[SS] & ~hist[SS+1];
    endtask

    task automatic check_all();
        chk("spike_pulse",   32'(spike_pulse),   32'(m_pulse));
        chk("count_valid",   32'(count_valid),   32'(m_valid));
        chk("count_data",    32'(count_data),    32'(clamp(m_res, 65535)));
        chk("count_sat",     32'(count_sat),     32'(m_res > 65535));
        chk("drop",          32'(drop),          32'(m_drop));
        chk("spike_pulse_4", 32'(spike_pulse_4), 32'(m_pulse));
        chk("count_valid_4", 32'(count_valid_4), 32'(m_valid));
        chk("count_data_4",  32'(count_data_4),  32'(clamp(m_res, 15)));
        chk("count_sat_4",   32'(count_sat_4),   32'(m_res > 15));
        chk("drop_4",        32'(drop_4),        32'(m_drop));
    endtask

    // Advance one clock, update the model, then compare 1 ns after the edge.
    task automatic cycle();
        @(posedge clk);
        if (!reset_n) model_reset();
        else          model_edge();
        #1;
        check_all();
        if (count_valid && count_ready) begin
            q16.push_back(int'(count_data));
            q4.push_back(int'(count_data_4));
            qs4.push_back(int'(count_sat_4));
        end
    endtask

    task automatic clear_results();
        q16.delete();
        q4.delete();
        qs4.delete();
    endtask

    task automatic check_reset_zero(input string tag);
        chk({tag, "_pulse"}, 32'(spike_pulse),  32'(0));
        chk({tag, "_valid"}, 32'(count_valid),  32'(0));
        chk({tag, "_data"},  32'(count_data),   32'(0));
        chk({tag, "_sat"},   32'(count_sat),    32'(0));
        chk({tag, "_drop"},  32'(drop),         32'(0));
        chk({tag, "_data4"}, 32'(count_data_4), 32'(0));
        chk({tag, "_drop4"}, 32'(drop_4),       32'(0));
        chk({tag, "_state"}, 32'(dut.state),    32'(ST_IDLE));
    endtask

    task automatic idle_cycles(input int n);
        enable   = 1'b0;
        spike_in = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();

        // Power-on reset: outputs must already be clear before any clock edge.
        #2;
        check_reset_zero("por");
        cycle();
        cycle();
        reset_n = 1'b1;
        idle_cycles(4);

        // Latency and basic windowing: win_len=100, 10 spikes 7 cycles apart.
        win_len     = 24'd100;
        count_ready = 1'b1;
        clear_results();
        for (int i = 0; i < 104; i++) begin
            enable   = (i < 100);
            spike_in = (i >= 3) && (i < 73) && (((i - 3) % 7) < 3);
            cycle();
            if (i == 4)  chk("lat_pulse_early", 32'(spike_pulse), 32'(0));
            if (i == 5)  chk("lat_pulse_on",    32'(spike_pulse), 32'(1));
            if (i == 6)  chk("lat_pulse_off",   32'(spike_pulse), 32'(0));
            if (i == 40) chk("lat_pulse_mid",   32'(spike_pulse), 32'(1));
            if (i == 99) chk("win_valid_before", 32'(count_valid), 32'(0));
            if (i == 100) begin
                chk("win_valid", 32'(count_valid), 32'(1));
                chk("win_data",  32'(count_data),  32'(10));
                chk("win_sat",   32'(count_sat),   32'(0));
            end
        end
        idle_cycles(4);

        // Back-to-back windows of 20; the spike at i=17 lands in the terminal cycle.
        win_len = 24'd20;
        clear_results();
        for (int i = 0; i < 45; i++) begin
            enable   = (i < 40);
            spike_in = (i == 1) || (i == 5) || (i == 9) || (i == 13) || (i == 17) ||
                       (i == 21) || (i == 25) || (i == 29);
            cycle();
        end
        chk("b2b_count", 32'(q16.size()), 32'(2));
        if (q16.size() >= 2) begin
            chk("b2b_first",  32'(q16[0]), 32'(5));
            chk("b2b_second", 32'(q16[1]), 32'(3));
        end
        idle_cycles(4);

        // Saturation: 20 spikes in a 50-cycle window, then 2 spikes.
        win_len = 24'd50;
        clear_results();
        for (int i = 0; i < 105; i++) begin
            enable   = (i < 100);
            spike_in = ((i < 40) && (i % 2 == 0)) || (i == 60) || (i == 70);
            cycle();
        end
        chk("sat_count", 32'(q4.size()), 32'(2));
        if (q4.size() >= 2) begin
            chk("sat_w16_first", 32'(q16[0]), 32'(20));
            chk("sat_w4_first",  32'(q4[0]),  32'(15));
            chk("sat_flag_first", 32'(qs4[0]), 32'(1));
            chk("sat_w4_second", 32'(q4[1]),  32'(2));
            chk("sat_flag_second", 32'(qs4[1]), 32'(0));
        end
        idle_cycles(4);

        // Backpressure: windows of 10 with w+1 spikes in window w.
        win_len = 24'd10;
        for (int i = 0; i < 46; i++) begin
            enable      = (i < 40);
            count_ready = (i == 20);
            spike_in    = (i < 40) && ((i % 10) % 2 == 0) && (((i % 10) / 2) <= (i / 10));
            cycle();
            if (i == 15) begin
                chk("bp_valid_1", 32'(count_valid), 32'(1));
                chk("bp_data_1",  32'(count_data),  32'(1));
            end
            if (i == 20) begin
                chk("bp_accept_data", 32'(count_data), 32'(2));
                chk("bp_accept_drop", 32'(drop),       32'(0));
            end
            if (i == 30) chk("bp_drop_set", 32'(drop), 32'(1));
            if (i == 45) begin
                chk("bp_held_valid", 32'(count_valid), 32'(1));
                chk("bp_held_data",  32'(count_data),  32'(2));
            end
        end
        count_ready = 1'b1;
        cycle();
        chk("bp_drained", 32'(count_valid), 32'(0));
        idle_cycles(3);

        // Abort: enable drops mid-window, nothing may be reported.
        win_len = 24'd50;
        clear_results();
        for (int i = 0; i < 80; i++) begin
            enable   = (i < 20);
            spike_in = $urandom_range(0, 1) != 0;
            cycle();
        end
        chk("abort_no_result", 32'(q16.size()), 32'(0));
        chk("abort_state",     32'(dut.state),  32'(ST_IDLE));

        // Zero window length never starts a window.
        win_len = '0;
        enable  = 1'b1;
        for (int i = 0; i < 30; i++) begin
            spike_in = $urandom_range(0, 1) != 0;
            cycle();
        end
        chk("zero_len_valid", 32'(count_valid), 32'(0));
        chk("zero_len_state", 32'(dut.state),   32'(ST_IDLE));
        idle_cycles(4);

        // Reset in the middle of an active window with spikes present.
        win_len = 24'd50;
        enable  = 1'b1;
        for (int i = 0; i < 30; i++) begin
            spike_in = (i % 3) != 0;
            cycle();
        end
        spike_in = 1'b1;
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_zero("mid_rst");
        spike_in = 1'b0;
        enable   = 1'b0;
        cycle();
        cycle();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("post_rst_no_pulse", 32'(spike_pulse), 32'(0));
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            enable      = $urandom_range(0, 29) != 0;
            win_len     = ($urandom_range(0, 9) == 0) ? '0 : WIN_W'($urandom_range(1, 25));
            count_ready = $urandom_range(0, 9) < 7;
            spike_in    = $urandom_range(0, 9) < 4;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spike_rx_counter.md
Name: spike_rx_counter

Overview:
- Receiving end of the free-running spike oscillator link.
- Takes an asynchronous spike line from an oscillator-style spike generator, where every rising edge is one spike.
- Synchronizes the line, detects edges and counts spikes over a programmable window of clk cycles.
- Hands each window count to the downstream rate/fitness logic over a valid/ready handshake.

Parameters:
- CNT_W, 16, width of the spike count per window.
- WIN_W, 24, width of the window-length input and the internal window counter.
- SYNC_STAGES, 2, number of flip-flops in the spike_in synchronizer chain (min 2).

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- spike_in  input  1  asynchronous spike line; each rising edge is one spike.
- enable  input  1  starts and continues windowed counting while high.
- win_len  input  WIN_W  window length in clk cycles; sampled at window start.
- spike_pulse  output  1  one-cycle strobe per detected spike.
- count_data  output  CNT_W  spike count of the last completed window.
- count_valid  output  1  count_data holds an unconsumed result.
- count_ready  input  1  consumer accepts count_data when high with count_valid.
- count_sat  output  1  qualifies count_data: that window saturated.
- drop  output  1  sticky: a completed window was discarded because the output was full.

Behaviour:
Clock and reset:
- One clock. Reset is asynchronous and active-low.
- While reset_n is low, all flops clear: sync chain, edge register, state=IDLE, window counter, accumulator, spike_pulse, count_data, count_valid, count_sat and drop all go to 0.

Synchronizer and edge detect:
- spike_in passes through SYNC_STAGES flops to give s_sync. s_prev is s_sync delayed by one cycle.
- An edge is s_sync & ~s_prev. spike_pulse is registered from the edge.
- A rising edge of spike_in that meets setup before clk edge k produces spike_pulse high in cycle k+SYNC_STAGES+1, for exactly 1 cycle.
- Falling edges are not counted.
- Pulses narrower than one clk period may be missed. This is a documented limitation, not an error.

State machine (IDLE, COUNT):
- IDLE: the accumulator holds 0.
  - On enable=1 and win_len!=0: latch win_len into win_left, clear the accumulator, go to COUNT.
  - If win_len==0: stay in IDLE.
- COUNT: each cycle, win_left decrements. On spike_pulse, the accumulator increments, saturating at 2^CNT_W-1 and setting a per-window sat bit.
- Terminal cycle (win_left==1): the spike_pulse of that cycle is included in the ending window.
  - The final value is offered to the output stage.
  - If enable is still 1 and win_len!=0, the next window starts on the very next cycle with no dead cycle: win_left=win_len reloaded, accumulator=0, sat=0.
  - Otherwise go to IDLE.
- enable falling during COUNT: abort next cycle, discard the partial count, go to IDLE. The pending output is untouched.
- win_len changes mid-window: no effect until the next window start.

Output stage:
- count_data, count_valid and count_sat are registered.
- A result is written in the cycle after the terminal cycle if either condition holds:
  - count_valid==0, or
  - count_valid & count_ready in the terminal cycle (a simultaneous accept and new result is allowed).
- Otherwise the new result is discarded and drop is set. drop stays set until reset.
- count_valid falls on accept when no new result is arriving in the same cycle.
- count_data and count_sat are stable while count_valid=1 and count_ready=0.

Decomposition:
- Shared package: state encoding (IDLE, COUNT) and the SYNC_STAGES minimum constant.
- One natural sub-module: spike_sync_edge, containing the synchronizer chain plus rising-edge detector. It outputs spike_pulse. It is reusable by other spike receivers.

Test Plan:
- Reset during activity: assert reset_n=0 mid-window with spikes present -> all outputs 0 asynchronously; after release, no spike_pulse until a new rising edge.
- Latency and windowing: SYNC_STAGES=2, win_len=100, 10 spikes spaced 7 cycles apart, count_ready=1 -> spike_pulse 3 cycles after each edge; count_valid one cycle after the terminal cycle with count_data=10, count_sat=0.
- Boundary spike: spike_pulse in the terminal cycle of window N -> counted in N, not N+1. Back-to-back windows show no gap; a 5-spike and a 3-spike window report 5 then 3.
- Saturation: CNT_W=4, 20 spikes in one window -> count_data=15, count_sat=1; the next window with 2 spikes reports 2, count_sat=0.
- Backpressure: count_ready=0 across two window ends -> first result held stable, drop=1 after the second window end. A result arriving in the same cycle as an accept (ready=1) is accepted with drop unchanged.
- Abort and zero length: enable dropped mid-window -> no new count_valid, state IDLE. win_len=0 with enable=1 -> no windows are started.
